// File: rtl/p_decoder_q.sv
`default_nettype none
// ============================================================================
// Module      : p_decoder_q
// Description : Four-entry show-ahead queue of 2-bit codes whose head entry is
//               presented decoded to one-hot, with occupancy, drop and tally.
// Revision    : 1.0 - initial release
// ============================================================================
module p_decoder_q #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic [1:0] in_code,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] out_onehot,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] level,
    output logic       drop,
    output logic [7:0] tally
);

    localparam int         PTR_W  = $clog2(DEPTH);
    localparam logic [2:0] C_FULL = 3'(DEPTH);

    logic [1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [2:0]       r_level;
    logic             r_drop;
    logic [7:0]       r_tally;

    logic w_push;
    logic w_pop;

    // Ready depends only on enable and registered occupancy, never on in_valid.
    assign in_ready  = E & (r_level != C_FULL);
    assign out_valid = (r_level != 3'd0);
    assign w_push    = in_valid & in_ready & ~rst;
    assign w_pop     = out_valid & out_ready;

    assign out_onehot = out_valid ? (4'b0001 << r_mem[r_rd]) : 4'b0000;
    assign level      = r_level;
    assign drop       = r_drop;
    assign tally      = r_tally;

    // Storage carries no reset; stale contents are masked by the level count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= in_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= 3'd0;
            r_drop  <= 1'b0;
            r_tally <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr    <= r_wr + 1'b1;
                r_tally <= r_tally + 8'd1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 3'd1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 3'd1;
            end
            if (in_valid && !in_ready && E) begin
                r_drop <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_p_decoder_q.sv
`default_nettype none
// ============================================================================
// Module      : tb_p_decoder_q
// Description : Scoreboard bench for p_decoder_q with a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_p_decoder_q;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       E = 1'b0;
    logic [1:0] in_code = 2'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic [3:0] out_onehot;
    logic       out_valid;
    logic [2:0] level;
    logic       drop;
    logic [7:0] tally;

    p_decoder_q #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .E          (E),
        .in_code    (in_code),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .drop       (drop),
        .tally      (tally)
    );

    always #5 clk = ~clk;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [1:0] exp_q[$];
    int         m_level = 0;
    logic       m_drop  = 1'b0;
    logic [7:0] m_tally = 8'd0;
    bit         mon_en  = 1'b0;
    logic [1:0] head;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented head against the scoreboard and retires it on handshake.
    always @(negedge clk) begin
        #3;
        if (mon_en) begin
            chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                head = exp_q[0];
                chk("out_onehot", int'(out_onehot), 1 << head);
                if (out_ready) void'(exp_q.pop_front());
            end else if (!out_valid) begin
                chk("idle_onehot", int'(out_onehot), 0);
            end
        end
    end

    // One cycle of stimulus; status outputs are checked against the model before the edge.
    task automatic drive(input bit e, input bit v, input logic [1:0] c, input bit r);
        bit m_push;
        bit m_pop;
        @(negedge clk);
        E = e; in_valid = v; in_code = c; out_ready = r;
        #2;
        chk("in_ready", int'(in_ready), int'(e && m_level < 4));
        chk("level", int'(level), m_level);
        chk("drop", int'(drop), int'(m_drop));
        chk("tally", int'(tally), int'(m_tally));
        m_push = v && e && (m_level < 4);
        m_pop  = (m_level > 0) && r;
        if (v && e && m_level == 4) m_drop = 1'b1;
        @(posedge clk);
        #1;
        if (m_push) begin
            exp_q.push_back(c);
            m_tally = m_tally + 8'd1;
        end
        m_level = m_level + int'(m_push) - int'(m_pop);
    endtask

    task automatic async_reset();
        @(negedge clk);
        mon_en = 1'b0;
        in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_onehot", int'(out_onehot), 0);
        chk("rst_tally", int'(tally), 0);
        chk("rst_drop", int'(drop), 0);
        chk("rst_in_ready", int'(in_ready), int'(E));
        exp_q.delete();
        m_level = 0; m_drop = 1'b0; m_tally = 8'd0;
        @(posedge clk);
        #1;
        chk("rst_no_push_level", int'(level), 0);
        chk("rst_no_push_tally", int'(tally), 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2;
        chk("init_level", int'(level), 0);
        chk("init_out_valid", int'(out_valid), 0);
        chk("init_onehot", int'(out_onehot), 0);
        chk("init_tally", int'(tally), 0);
        chk("init_drop", int'(drop), 0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Decode walk with the consumer always ready.
        for (int i = 0; i < 4; i++) drive(1, 1, 2'(i), 1);
        drive(1, 0, 2'd0, 1);
        chk("walk_tally", int'(tally), 4);

        // Fill, overflow attempt, drain.
        drive(1, 1, 2'd3, 0);
        drive(1, 1, 2'd2, 0);
        drive(1, 1, 2'd1, 0);
        drive(1, 1, 2'd0, 0);
        drive(1, 1, 2'd1, 0);
        chk("full_level", int'(level), 4);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_drop", int'(drop), 1);
        chk("full_tally", int'(tally), 8);
        repeat (5) drive(1, 0, 2'd0, 1);

        // Full queue with push attempt and pop on the same edge.
        for (int i = 0; i < 4; i++) drive(1, 1, 2'(i), 0);
        drive(1, 1, 2'd2, 1);
        chk("full_pop_only", int'(level), 3);
        drive(1, 1, 2'd2, 0);
        chk("full_refill", int'(level), 4);
        repeat (5) drive(1, 0, 2'd0, 1);

        // Enable gating blocks pushes but not draining, and never sets drop.
        async_reset();
        drive(1, 1, 2'd1, 0);
        drive(1, 1, 2'd2, 0);
        repeat (3) drive(0, 1, 2'd3, 1);
        chk("gate_level", int'(level), 0);
        chk("gate_drop", int'(drop), 0);
        drive(1, 1, 2'd3, 1);
        drive(1, 0, 2'd0, 1);
        chk("gate_resume_tally", int'(tally), 3);

        // Tally and pointer wrap, then asynchronous reset with entries queued.
        async_reset();
        for (int i = 0; i < 257; i++) drive(1, 1, 2'($urandom_range(0, 3)), 1);
        chk("wrap_tally", int'(tally), 1);
        drive(1, 1, 2'($urandom_range(0, 3)), 0);
        drive(1, 1, 2'($urandom_range(0, 3)), 0);
        chk("pre_rst_level", int'(level), 3);
        async_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 8) != 0, ($urandom % 10) < 7,
                  2'($urandom_range(0, 3)), ($urandom % 2) == 1);
        end
        repeat (6) drive(1, 0, 2'd0, 1);
        chk("final_level", int'(level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
